// File: rtl/flash_word_fetch.sv
// Turns the QSPI XIP reader's byte stream into little-endian 32-bit word reads,
// keeping the stream open for sequential fetches with an optional one-word prefetch.
module flash_word_fetch #(
  parameter logic PREFETCH = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  input  logic        flash_setup_done,
  output logic [23:0] flash_addr,
  output logic        flash_do_read,
  input  logic        flash_data_ready,
  input  logic [7:0]  flash_data
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    GAP         = 3'd1,
    READ        = 3'd2,
    STREAM_FILL = 3'd3,
    STREAM_WAIT = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic        req_ready_r, req_ready_s;
  logic        resp_valid_r, resp_valid_s;
  logic [31:0] resp_data_r, resp_data_s;
  logic        do_read_r, do_read_s;
  logic [23:0] flash_addr_r, flash_addr_s;
  logic [1:0]  count_r, count_s;
  logic [23:0] word_r, word_s;
  logic [31:0] buf_data_r, buf_data_s;
  logic [23:0] buf_addr_r, buf_addr_s;
  logic        buf_valid_r, buf_valid_s;
  logic        pend_r, pend_s;

  logic [23:0] req_word_s;
  logic        accept_s;
  logic        strobe_s;
  logic        last_s;
  logic [31:0] full_word_s;

  assign req_word_s  = req_addr & 24'hFFFFFC;
  assign accept_s    = req_valid && req_ready_r;
  // Bytes are only meaningful while the stream is enabled.
  assign strobe_s    = flash_data_ready && do_read_r;
  assign last_s      = strobe_s && (count_r == 2'd3);
  assign full_word_s = {flash_data, word_r};

  // Next-state, byte assembly and registered-output decode.
  always_comb begin
    state_s      = state_r;
    resp_valid_s = 1'b0;
    resp_data_s  = resp_data_r;
    flash_addr_s = flash_addr_r;
    word_s       = word_r;
    buf_data_s   = buf_data_r;
    buf_addr_s   = buf_addr_r;
    buf_valid_s  = buf_valid_r;
    pend_s       = pend_r;

    if (strobe_s) begin
      count_s = count_r + 2'd1;
      case (count_r)
        2'd0:    word_s[7:0]   = flash_data;
        2'd1:    word_s[15:8]  = flash_data;
        2'd2:    word_s[23:16] = flash_data;
        default: word_s        = word_r;
      endcase
    end else begin
      count_s = count_r;
    end

    case (state_r)
      IDLE, STREAM_WAIT: begin
        if (accept_s) begin
          if (PREFETCH && buf_valid_r && (req_word_s == buf_addr_r)) begin
            resp_valid_s = 1'b1;
            resp_data_s  = buf_data_r;
            flash_addr_s = buf_addr_r + 24'd4;
            buf_valid_s  = 1'b0;
            pend_s       = 1'b0;
            state_s      = GAP;
          end else begin
            flash_addr_s = req_word_s;
            buf_valid_s  = 1'b0;
            pend_s       = 1'b1;
            count_s      = 2'd0;
            state_s      = READ;
          end
        end else begin
          state_s = IDLE;
        end
      end
      GAP: begin
        count_s = 2'd0;
        if (pend_r || !PREFETCH) begin
          state_s = READ;
        end else begin
          state_s = STREAM_FILL;
        end
      end
      READ: begin
        if (last_s) begin
          resp_valid_s = 1'b1;
          resp_data_s  = full_word_s;
          pend_s       = 1'b0;
          flash_addr_s = flash_addr_r + 24'd4;
          state_s      = PREFETCH ? STREAM_FILL : IDLE;
        end else begin
          state_s = READ;
        end
      end
      STREAM_FILL: begin
        // flash_addr tracks the word currently being filled.
        if (accept_s && (req_word_s != flash_addr_r)) begin
          flash_addr_s = req_word_s;
          count_s      = 2'd0;
          pend_s       = 1'b1;
          buf_valid_s  = 1'b0;
          state_s      = GAP;
        end else if (last_s) begin
          if (pend_r || accept_s) begin
            resp_valid_s = 1'b1;
            resp_data_s  = full_word_s;
            pend_s       = 1'b0;
            flash_addr_s = flash_addr_r + 24'd4;
          end else begin
            buf_data_s  = full_word_s;
            buf_addr_s  = flash_addr_r;
            buf_valid_s = 1'b1;
            state_s     = STREAM_WAIT;
          end
        end else if (accept_s) begin
          pend_s = 1'b1;
        end else begin
          pend_s = pend_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    do_read_s   = (state_s == READ) || (state_s == STREAM_FILL);
    req_ready_s = flash_setup_done && !pend_s &&
                  ((state_s == IDLE) || (state_s == STREAM_WAIT) || (state_s == STREAM_FILL));
  end

  // State and output registers; synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      req_ready_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_data_r  <= 32'd0;
      do_read_r    <= 1'b0;
      flash_addr_r <= 24'd0;
      count_r      <= 2'd0;
      word_r       <= 24'd0;
      buf_data_r   <= 32'd0;
      buf_addr_r   <= 24'd0;
      buf_valid_r  <= 1'b0;
      pend_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      req_ready_r  <= req_ready_s;
      resp_valid_r <= resp_valid_s;
      resp_data_r  <= resp_data_s;
      do_read_r    <= do_read_s;
      flash_addr_r <= flash_addr_s;
      count_r      <= count_s;
      word_r       <= word_s;
      buf_data_r   <= buf_data_s;
      buf_addr_r   <= buf_addr_s;
      buf_valid_r  <= buf_valid_s;
      pend_r       <= pend_s;
    end
  end

  assign req_ready     = req_ready_r;
  assign resp_valid    = resp_valid_r;
  assign resp_data     = resp_data_r;
  assign flash_do_read = do_read_r;
  assign flash_addr    = flash_addr_r;

endmodule

// File: tb/tb_flash_word_fetch.sv
// Scoreboard bench for flash_word_fetch: behavioural flash reader, directed
// protocol checks and randomized request traffic against a flash memory model.
module tb_flash_word_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [23:0] req_addr = 24'd0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        flash_setup_done = 1'b0;
  logic [23:0] flash_addr;
  logic        flash_do_read;
  logic        flash_data_ready = 1'b0;
  logic [7:0]  flash_data = 8'd0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int falls = 0;
  int resp_seen = 0;
  logic prev_dr = 1'b0;
  logic [31:0] exp_q[$];

  logic        rd_active = 1'b0;
  logic [23:0] rd_addr = 24'd0;
  int          rd_wait = 0;

  flash_word_fetch #(.PREFETCH(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .flash_setup_done(flash_setup_done), .flash_addr(flash_addr),
    .flash_do_read(flash_do_read), .flash_data_ready(flash_data_ready),
    .flash_data(flash_data)
  );

  always #5 clk = ~clk;

  // Flash contents: word 0x100 holds 11,22,33,44; elsewhere an address hash.
  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    logic [3:0] n;
    if ((a & 24'hFFFFFC) == 24'h000100) begin
      n = {2'b00, a[1:0]} + 4'd1;
      return {n, n};
    end
    return (a[7:0] ^ a[15:8] ^ a[23:16]) + 8'h5A + {a[1:0], 6'd0};
  endfunction

  function automatic logic [31:0] mem_word(input logic [23:0] a);
    logic [23:0] w;
    w = a & 24'hFFFFFC;
    return {mem_byte(w + 24'd3), mem_byte(w + 24'd2), mem_byte(w + 24'd1), mem_byte(w)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reader: latches flash_addr when do_read rises, streams sequential bytes, stops when it falls.
  initial forever begin
    @(posedge clk);
    #1;
    if (!flash_do_read) begin
      rd_active = 1'b0;
      flash_data_ready = 1'b0;
    end else if (!rd_active) begin
      rd_active = 1'b1;
      rd_addr = flash_addr;
      rd_wait = int'($urandom_range(1, 4));
      flash_data_ready = 1'b0;
    end else if (rd_wait > 0) begin
      rd_wait--;
      flash_data_ready = 1'b0;
    end else begin
      flash_data_ready = 1'b1;
      flash_data = mem_byte(rd_addr);
      rd_addr = rd_addr + 24'd1;
      rd_wait = int'($urandom_range(0, 2));
    end
  end

  // Monitor: every response pops the scoreboard.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (prev_dr && !flash_do_read) falls++;
      if (resp_valid) begin
        resp_seen++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_resp: got %h expected no response", resp_data);
        end else begin
          check("resp_data", resp_data, exp_q.pop_front());
        end
      end
    end
    prev_dr = flash_do_read;
  end

  task automatic issue(input logic [23:0] a);
    int t;
    logic [1:0] lo;
    @(negedge clk);
    lo = 2'($urandom_range(0, 3));
    req_addr = {a[23:2], lo};
    req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b0;
      return;
    end
    exp_q.push_back(mem_word(a));
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int t;
    t = 0;
    @(posedge clk);
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      check("resp_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic wait_strobes(input int n);
    int seen;
    int t;
    seen = 0;
    t = 0;
    while (seen < n && t < 200) begin
      @(negedge clk);
      if (flash_data_ready && flash_do_read) seen++;
      t++;
    end
    if (seen < n) check("strobe_timeout", seen, n);
  endtask

  initial begin
    int f0;
    int r0;
    logic [23:0] last_a;
    logic [23:0] a;

    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_do_read", {31'd0, flash_do_read}, 32'd0);
    check("rst_flash_addr", {8'd0, flash_addr}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("nosetup_req_ready", {31'd0, req_ready}, 32'd0);
    check("nosetup_do_read", {31'd0, flash_do_read}, 32'd0);
    flash_setup_done = 1'b1;
    @(negedge clk);
    check("setup_req_ready", {31'd0, req_ready}, 32'd1);

    // Miss from idle: do_read rises the cycle after acceptance.
    check("idle_do_read_low", {31'd0, flash_do_read}, 32'd0);
    issue(24'h000100);
    check("miss_do_read_rise", {31'd0, flash_do_read}, 32'd1);
    check("miss_flash_addr", {8'd0, flash_addr}, 32'h00000100);
    wait_resp();

    // Sequential word answered from the open stream without a gap.
    f0 = falls;
    issue(24'h000104);
    wait_resp();
    check("stream_no_gap", falls, f0);

    // Buffer hit after the stream closed on buffer full.
    issue(24'h000200);
    wait_resp();
    repeat (50) @(negedge clk);
    check("drop_on_full", {31'd0, flash_do_read}, 32'd0);
    issue(24'h000204);
    check("hit_latency", {31'd0, resp_valid}, 32'd1);
    check("hit_gap_low", {31'd0, flash_do_read}, 32'd0);
    @(negedge clk);
    check("hit_restart", {31'd0, flash_do_read}, 32'd1);
    check("hit_restart_addr", {8'd0, flash_addr}, 32'h00000208);

    // Non-sequential request while the prefetch buffer is partly filled.
    issue(24'h000208);
    wait_resp();
    wait_strobes(1);
    issue(24'h002000);
    check("nonseq_gap_low", {31'd0, flash_do_read}, 32'd0);
    check("nonseq_addr", {8'd0, flash_addr}, 32'h00002000);
    @(negedge clk);
    check("nonseq_restart", {31'd0, flash_do_read}, 32'd1);
    wait_resp();

    // Top-of-space word: prefetch address wraps to zero.
    issue(24'hFFFFFC);
    wait_resp();
    check("wrap_addr", {8'd0, flash_addr}, 32'h00000000);
    f0 = falls;
    issue(24'h000000);
    wait_resp();
    check("wrap_stream", falls, f0);

    // Reset two bytes into a read: no response ever appears.
    issue(24'h003000);
    wait_strobes(2);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_do_read", {31'd0, flash_do_read}, 32'd0);
    check("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    exp_q.delete();
    r0 = resp_seen;
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("midrst_no_resp", resp_seen, r0);

    // Randomized traffic mixing sequential, near and far addresses.
    last_a = 24'h000400;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0, 1:    a = last_a + 24'd4;
        2:       a = last_a + 24'd8;
        3:       a = 24'($urandom_range(0, 255)) << 2;
        default: a = 24'($urandom) & 24'hFFFFFC;
      endcase
      repeat ($urandom_range(0, 40)) @(negedge clk);
      issue(a);
      last_a = a;
      if ($urandom_range(0, 1) == 1) wait_resp();
    end
    wait_resp();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
